// File: rtl/probe_pkg.sv
// probe_pkg: shared types and constants for the probe_bank debug-pin driver.
//   probe_mode_e        - per-channel conditioning mode
//   probe_cfg_t         - 32-bit channel config word layout
//   PROBE_CFG_RESET     - reset config (enabled passthrough)
//   probe_cfg_from_word - converts a written word to a stored config,
//                         zeroing reserved bits and unused len/duty bits
package probe_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'd0,
    MODE_STRETCH = 2'd1,
    MODE_TOGGLE  = 2'd2,
    MODE_PWM     = 2'd3
  } probe_mode_e;

  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  duty;
    logic [3:0]  rsvd;
    logic        enable;
    logic        invert;
    probe_mode_e mode;
  } probe_cfg_t;

  localparam int CFG_DUTY_LSB = 8;
  localparam int CFG_LEN_LSB  = 16;

  localparam probe_cfg_t PROBE_CFG_RESET = '{
    len:    16'd0,
    duty:   8'd0,
    rsvd:   4'd0,
    enable: 1'b1,
    invert: 1'b0,
    mode:   MODE_DIRECT
  };

  function automatic probe_cfg_t probe_cfg_from_word(input logic [31:0] w,
                                                     input int stretch_w,
                                                     input int pwm_w);
    probe_cfg_t c;
    logic [15:0] len_mask;
    logic [7:0]  duty_mask;
    len_mask  = 16'((32'd1 << stretch_w) - 32'd1);
    duty_mask = 8'((32'd1 << pwm_w) - 32'd1);
    c         = probe_cfg_t'(w);
    c.rsvd    = '0;
    c.duty    = w[CFG_DUTY_LSB +: 8] & duty_mask;
    c.len     = w[CFG_LEN_LSB +: 16] & len_mask;
    return c;
  endfunction

endpackage

// File: rtl/probe_channel.sv
// probe_channel: conditions one debug signal into one registered pin drive.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   i_we        - write strobe already decoded for this channel
//   i_wdata     - config word being written
//   i_sig       - debug signal, synchronous to clk
//   i_pwm_cnt   - shared free-running PWM counter
//   o_cfg       - stored config word (for readback)
//   o_out       - registered pin drive
module probe_channel
  import probe_pkg::*;
#(
  parameter int STRETCH_W = 16,
  parameter int PWM_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [31:0]      i_wdata,
  input  logic             i_sig,
  input  logic [PWM_W-1:0] i_pwm_cnt,
  output logic [31:0]      o_cfg,
  output logic             o_out
);

  probe_cfg_t           r_cfg;
  logic [STRETCH_W-1:0] r_cnt;
  logic                 r_tog;
  logic                 r_prev;
  logic                 r_out;

  logic [STRETCH_W-1:0] w_len;
  logic [STRETCH_W-1:0] w_cnt_next;
  logic [PWM_W-1:0]     w_duty;
  logic                 w_cnt_nz;
  logic                 w_rise;
  logic                 w_tog_next;
  logic                 w_mode_out;
  logic                 w_out_next;

  assign w_len  = r_cfg.len[STRETCH_W-1:0];
  assign w_duty = r_cfg.duty[PWM_W-1:0];

  always_comb begin
    w_cnt_nz   = (r_cnt != '0);
    w_cnt_next = r_cnt;
    if (i_sig) begin
      w_cnt_next = w_len;
    end else if (w_cnt_nz) begin
      w_cnt_next = r_cnt - 1'b1;
    end
    w_rise     = i_sig & ~r_prev;
    w_tog_next = r_tog ^ w_rise;
    w_mode_out = i_sig;
    case (r_cfg.mode)
      MODE_DIRECT:  w_mode_out = i_sig;
      MODE_STRETCH: w_mode_out = i_sig | w_cnt_nz;
      MODE_TOGGLE:  w_mode_out = w_tog_next;
      MODE_PWM:     w_mode_out = (i_pwm_cnt < w_duty);
    endcase
    // enable gates after invert so a disabled pin is always driven low
    w_out_next = r_cfg.enable & (w_mode_out ^ r_cfg.invert);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg  <= PROBE_CFG_RESET;
      r_cnt  <= '0;
      r_tog  <= 1'b0;
      r_prev <= 1'b0;
      r_out  <= 1'b0;
    end else begin
      // edge history always tracks the input so a reconfig never fakes an edge
      r_prev <= i_sig;
      r_out  <= w_out_next;
      if (i_we) begin
        r_cfg <= probe_cfg_from_word(i_wdata, STRETCH_W, PWM_W);
        r_cnt <= '0;
        r_tog <= 1'b0;
      end else begin
        r_cnt <= w_cnt_next;
        r_tog <= w_tog_next;
      end
    end
  end

  assign o_cfg = r_cfg;
  assign o_out = r_out;

endmodule

// File: rtl/probe_bank.sv
// probe_bank: multi-channel debug output driver for board probe/LED pins.
// Each channel is DIRECT, STRETCH, TOGGLE or PWM with invert and enable,
// configured through a small register port.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   sig_in      - debug signals, one per channel
//   cfg_we/re   - write / read strobes
//   cfg_addr    - channel index; values >= NUM_CH are ignored / read 0
//   cfg_wdata   - config word to write
//   cfg_rdata   - registered read data, cfg_rvalid marks it
//   out         - registered pin drives
module probe_bank
  import probe_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int STRETCH_W = 16,
  parameter int PWM_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       sig_in,
  input  logic                    cfg_we,
  input  logic                    cfg_re,
  input  logic [$clog2(NUM_CH):0] cfg_addr,
  input  logic [31:0]             cfg_wdata,
  output logic [31:0]             cfg_rdata,
  output logic                    cfg_rvalid,
  output logic [NUM_CH-1:0]       out
);

  localparam int AW = $clog2(NUM_CH) + 1;

  logic [PWM_W-1:0]  r_pwm_cnt;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic [NUM_CH-1:0] w_we;
  logic [31:0]       w_cfg [NUM_CH];
  logic [31:0]       w_rd_data;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    // out-of-range addresses match no channel, so those writes fall away
    assign w_we[gi] = cfg_we && (cfg_addr == AW'(gi));

    probe_channel #(
      .STRETCH_W (STRETCH_W),
      .PWM_W     (PWM_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_we[gi]),
      .i_wdata   (cfg_wdata),
      .i_sig     (sig_in[gi]),
      .i_pwm_cnt (r_pwm_cnt),
      .o_cfg     (w_cfg[gi]),
      .o_out     (out[gi])
    );
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_addr == AW'(i)) begin
        w_rd_data = w_cfg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_rvalid  <= cfg_re;
      // sampled before the channel register updates, so a same-cycle write reads old data
      if (cfg_re) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  assign cfg_rdata  = r_rdata;
  assign cfg_rvalid = r_rvalid;

endmodule

// File: tb/tb_probe_bank.sv
module tb_probe_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sig_in;
  logic        cfg_we;
  logic        cfg_re;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid;
  logic [7:0]  out;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         tgt;
    logic [7:0] mask;
    logic [7:0] val;
  } oexp_t;

  oexp_t       oq[$];
  logic [31:0] rq[$];

  probe_bank #(.NUM_CH(8), .STRETCH_W(16), .PWM_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .cfg_we     (cfg_we),
    .cfg_re     (cfg_re),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid),
    .out        (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] s);
    @(negedge clk);
    sig_in = s;
    cfg_we = 1'b0;
    cfg_re = 1'b0;
  endtask

  task automatic expect_out(input logic [7:0] m, input logic [7:0] v);
    oexp_t e;
    e.tgt  = cyc + 1;
    e.mask = m;
    e.val  = v & m;
    oq.push_back(e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_re    = 1'b0;
    cfg_addr  = a;
    cfg_wdata = d;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    cfg_we   = 1'b0;
    cfg_re   = 1'b1;
    cfg_addr = a;
    rq.push_back(exp);
  endtask

  task automatic wrrd(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_re    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    rq.push_back(exp);
  endtask

  task automatic count_high(input int bit_idx, output int hi);
    hi = 0;
    repeat (256) begin
      @(negedge clk);
      hi += int'(out[bit_idx]);
    end
  endtask

  // monitor: pops expected pin values by target cycle and read data on rvalid
  always @(negedge clk) begin
    oexp_t e;
    if (rst_n) begin
      while (oq.size() > 0 && oq[0].tgt <= cyc) begin
        e = oq.pop_front();
        if (e.tgt < cyc) begin
          checks++;
          errors++;
          $display("FAIL out_late: entry for cycle %0d unchecked at cycle %0d", e.tgt, cyc);
        end else begin
          chk($sformatf("out@%0d", cyc), {24'd0, out & e.mask}, {24'd0, e.val});
        end
      end
      if (cfg_rvalid) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected: got rvalid=1 with data %h expected no read", cfg_rdata);
        end else begin
          chk("cfg_rdata", cfg_rdata, rq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] spat;
    logic [7:0] sexp;
    logic [7:0] tpat;
    logic [7:0] texp;
    int         hi;

    rst_n     = 1'b0;
    sig_in    = 8'h00;
    cfg_we    = 1'b0;
    cfg_re    = 1'b0;
    cfg_addr  = 4'd0;
    cfg_wdata = 32'd0;
    #2;
    chk("reset_out", {24'd0, out}, 32'd0);
    chk("reset_rvalid", {31'd0, cfg_rvalid}, 32'd0);
    chk("reset_rdata", cfg_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // default passthrough
    drive(8'hA5); expect_out(8'hFF, 8'hA5);
    drive(8'hA5); expect_out(8'hFF, 8'hA5);
    drive(8'h5A); expect_out(8'hFF, 8'h5A);
    rd(4'd0, 32'h0000_0008);
    drive(8'h00); expect_out(8'hFF, 8'h00);

    // ch1 stretch len=4: single-cycle pulse -> 5 high cycles
    wr(4'd1, 32'h0004_0009);
    drive(8'h00); expect_out(8'h02, 8'h00);
    spat = 8'b0000_0001;
    sexp = 8'b0001_1111;
    for (int j = 0; j < 8; j++) begin
      drive(spat[j] ? 8'h02 : 8'h00);
      expect_out(8'h02, sexp[j] ? 8'h02 : 8'h00);
    end

    // ch2 toggle: rising edges at steps 0,3,6, held levels do nothing
    wr(4'd2, 32'h0000_000A);
    tpat = 8'b1100_1011;
    texp = 8'b1100_0111;
    for (int j = 0; j < 8; j++) begin
      drive(tpat[j] ? 8'h04 : 8'h00);
      expect_out(8'h04, texp[j] ? 8'h04 : 8'h00);
    end
    drive(8'h00);

    // ch3 PWM duty windows
    wr(4'd3, 32'h0000_400B);
    drive(8'h00); drive(8'h00);
    count_high(3, hi);
    chk("pwm_duty64", hi, 32'd64);
    wr(4'd3, 32'h0000_000B);
    drive(8'h00); drive(8'h00);
    count_high(3, hi);
    chk("pwm_duty0", hi, 32'd0);
    wr(4'd3, 32'h0000_FF0B);
    drive(8'h00); drive(8'h00);
    count_high(3, hi);
    chk("pwm_duty255", hi, 32'd255);

    // ch1 long stretch, then rewrite to direct mid-stretch
    wr(4'd1, 32'h0064_0009);
    drive(8'h00);
    drive(8'h02); expect_out(8'h02, 8'h02);
    for (int j = 0; j < 5; j++) begin
      drive(8'h00); expect_out(8'h02, 8'h02);
    end
    wr(4'd1, 32'h0000_0008);
    drive(8'h00); expect_out(8'h02, 8'h00);
    drive(8'h02); expect_out(8'h02, 8'h02);
    drive(8'h00); expect_out(8'h02, 8'h00);

    // ch4 disabled+inverted stays low; ch5 enabled+inverted
    wr(4'd4, 32'h0000_0004);
    wr(4'd5, 32'h0000_000C);
    drive(8'h00); expect_out(8'h30, 8'h20);
    drive(8'h30); expect_out(8'h30, 8'h00);
    drive(8'h10); expect_out(8'h30, 8'h20);

    // out-of-range write and reads; reserved bits cleared on readback
    wr(4'd8, 32'h0000_000B);
    wr(4'd6, 32'hFFFF_FFF8);
    drive(8'h01); expect_out(8'h01, 8'h01);
    rd(4'd0, 32'h0000_0008);
    rd(4'd1, 32'h0000_0008);
    rd(4'd2, 32'h0000_000A);
    rd(4'd4, 32'h0000_0004);
    rd(4'd6, 32'hFFFF_FF08);
    rd(4'd7, 32'h0000_0008);
    rd(4'd8, 32'h0000_0000);
    rd(4'd15, 32'h0000_0000);
    wrrd(4'd7, 32'h0000_000C, 32'h0000_0008);
    rd(4'd7, 32'h0000_000C);
    drive(8'hFF);
    rd(4'd2, 32'h0000_000A);
    drive(8'hFF);
    drive(8'hFF);
    drive(8'hFF);

    // async reset mid-operation
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_out", {24'd0, out}, 32'd0);
    chk("midreset_rdata", cfg_rdata, 32'd0);
    chk("midreset_rvalid", {31'd0, cfg_rvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h3C); expect_out(8'hFF, 8'h3C);
    rd(4'd2, 32'h0000_0008);
    drive(8'h00); expect_out(8'hFF, 8'h00);
    repeat (4) drive(8'h00);

    chk("out_queue_drained", oq.size(), 32'd0);
    chk("read_queue_drained", rq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
